mem_arbiter_2p: RTL and testbench

- Shared main-memory responder for the dual-core MIPS. It serves read/write requests from the two per-core cache controllers against the single `memoria_principal` RAM.
- Arbitrates between the two cores round-robin and sequences the RAM's 1-cycle registered read latency.
- Returns an ack plus read data to the requesting core.
- On every completed write, broadcasts an invalidate to the other core's cache so it drops any stale line.

---
 rtl/mips_mc_pkg.sv | 15 +
 rtl/mem_arbiter_2p_rr.sv | 32 +++
 rtl/mem_arbiter_2p.sv | 109 ++++++++++
 tb/tb_mem_arbiter_2p.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// Shared constants and types for the dual-core memory controller.
// No logic here; state encoding is fixed so waveforms decode consistently.
package mips_mc_pkg;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic core_id_t;
endpackage

// File: rtl/mem_arbiter_2p_rr.sv
// Two-way round-robin grant: combinational pick, history updated on completion.
// Zero latency grant; requesters are never dropped, only made to wait.
module rr_arbiter2
    import mips_mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_done,
    input  core_id_t   i_done_id,
    output core_id_t   o_gnt,
    output logic       o_any
);
    core_id_t r_last_grant;

    // Reset to core 1 so core 0 wins the first conflict.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= 1'b1;
        end else if (i_done) begin
            r_last_grant <= i_done_id;
        end
    end

    always_comb begin
        o_any = |i_req;
        o_gnt = i_req[1];
        if (&i_req) begin
            o_gnt = ~r_last_grant;
        end
    end
endmodule

// File: rtl/mem_arbiter_2p.sv
// Shared RAM responder for two cache controllers; write completion invalidates the other core.
// Read ack 3 cycles, write ack 2 cycles after the IDLE sample; losers stall until acked.
module mem_arbiter_2p #(
    parameter int ADDR_W = mips_mc_pkg::ADDR_W,
    parameter int DATA_W = mips_mc_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_rd,
    input  logic [1:0]        req_wr,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        stall,
    output logic [1:0]        inv_valid,
    output logic [ADDR_W-1:0] inv_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_rden,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);
    import mips_mc_pkg::*;

    state_t            r_state;
    state_t            w_next;
    core_id_t          r_gnt;
    core_id_t          w_gnt;
    logic              w_any;
    logic              w_done;
    logic              r_wr;
    logic [1:0]        w_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] r_inv_addr;
    logic [DATA_W-1:0] r_mem_data;
    logic [DATA_W-1:0] r_rdata;

    assign w_req  = req_rd | req_wr;
    assign w_done = (r_state == DONE);

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req     (w_req),
        .i_done    (w_done),
        .i_done_id (r_gnt),
        .o_gnt     (w_gnt),
        .o_any     (w_any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = ISSUE;
            ISSUE:   w_next = r_wr ? DONE : WAIT;
            WAIT:    w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // mem_addr doubles as the latched request address; rd+wr together is a write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt      <= 1'b0;
            r_wr       <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_rdata    <= '0;
            r_inv_addr <= '0;
        end else begin
            if (r_state == IDLE && w_any) begin
                r_gnt      <= w_gnt;
                r_wr       <= req_wr[w_gnt];
                r_mem_addr <= w_gnt ? req_addr1 : req_addr0;
                if (req_wr[w_gnt]) begin
                    r_mem_data <= w_gnt ? req_wdata1 : req_wdata0;
                end
            end
            if (r_state == WAIT) begin
                r_rdata <= mem_q;
            end
            if (r_state == ISSUE && r_wr) begin
                r_inv_addr <= r_mem_addr;
            end
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_data  = r_mem_data;
    assign rdata     = r_rdata;
    assign inv_addr  = r_inv_addr;
    assign mem_rden  = (r_state == ISSUE) && !r_wr;
    assign mem_wren  = (r_state == ISSUE) && r_wr;
    assign ack       = w_done ? (r_gnt ? 2'b10 : 2'b01) : 2'b00;
    assign inv_valid = (w_done && r_wr) ? (r_gnt ? 2'b01 : 2'b10) : 2'b00;
    assign stall     = w_req & ~ack;
endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Randomised scoreboard bench for mem_arbiter_2p with a word-array reference memory.
module tb_mem_arbiter_2p;
    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd0, rd1, wr0, wr1;
    logic [11:0] a0, a1;
    logic [31:0] d0, d1;
    logic [1:0]  ack, stall, inv_valid;
    logic [31:0] rdata, mem_data, mem_q;
    logic [11:0] inv_addr, mem_addr;
    logic        mem_rden, mem_wren;

    logic [31:0] ram     [0:4095];
    logic [31:0] ref_mem [0:4095];
    exp_t        q0[$];
    exp_t        q1[$];
    int          ordq[$];
    int          tests = 0;
    int          fails = 0;
    int          ack_cnt = 0, rden_cnt = 0, wren_cnt = 0;
    logic [11:0] wr_addr_seen;
    logic [31:0] wr_data_seen;

    always #5 clk = ~clk;

    mem_arbiter_2p dut (
        .clk        (clk),
        .rst        (rst),
        .req_rd     ({rd1, rd0}),
        .req_wr     ({wr1, wr0}),
        .req_addr0  (a0),
        .req_addr1  (a1),
        .req_wdata0 (d0),
        .req_wdata1 (d1),
        .ack        (ack),
        .rdata      (rdata),
        .stall      (stall),
        .inv_valid  (inv_valid),
        .inv_addr   (inv_addr),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_rden   (mem_rden),
        .mem_wren   (mem_wren),
        .mem_q      (mem_q)
    );

    function automatic logic [31:0] pat(input int a);
        if (a == 'h010) return 32'hDEADBEEF;
        return 32'hC0DE0000 ^ (32'(a) * 32'h00010003);
    endfunction

    // RAM with one-cycle registered read.
    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = pat(i);
        mem_q = '0;
        forever begin
            @(posedge clk);
            if (mem_wren) ram[mem_addr] = mem_data;
            if (mem_rden) mem_q = ram[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops per-core expectations whenever an ack appears.
    always @(negedge clk) begin
        exp_t e;
        bit   got;
        if (rd0 | rd1 | wr0 | wr1)
            chk("stall", 32'(stall), 32'({rd1 | wr1, rd0 | wr0} & ~ack));
        if (rst) begin
            if (mem_rden) rden_cnt++;
            if (mem_wren) begin
                wren_cnt++;
                wr_addr_seen = mem_addr;
                wr_data_seen = mem_data;
            end
            if (ack != 2'b00) ack_cnt++;
            if (ack == 2'b00 && inv_valid != 2'b00) begin
                tests++; fails++;
                $display("FAIL inv_without_ack: got %b expected 00", inv_valid);
            end
            for (int i = 0; i < 2; i++) begin
                if (ack[i]) begin
                    got = 1'b0;
                    if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
                    if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
                    if (!got) begin
                        tests++; fails++;
                        $display("FAIL unexpected_ack: got ack on core %0d expected none", i);
                    end else if (e.wr) begin
                        chk("inv_valid", 32'(inv_valid), (i == 0) ? 32'd2 : 32'd1);
                        chk("inv_addr", 32'(inv_addr), 32'(e.addr));
                    end else begin
                        chk("rdata", rdata, e.data);
                        chk("inv_on_read", 32'(inv_valid), 32'd0);
                    end
                    if (ordq.size() > 0) chk("grant_order", 32'(i), 32'(ordq.pop_front()));
                end
            end
        end
    end

    task automatic txn(input int c, input bit rd, input bit wr, input logic [11:0] a,
                       input logic [31:0] d, output int lat);
        exp_t e;
        int   n;
        e.wr   = wr;
        e.addr = a;
        e.data = wr ? d : ref_mem[a];
        if (wr) ref_mem[a] = d;
        if (c == 0) begin q0.push_back(e); rd0 = rd; wr0 = wr; a0 = a; d0 = d; end
        else        begin q1.push_back(e); rd1 = rd; wr1 = wr; a1 = a; d1 = d; end
        n   = 0;
        lat = -1;
        while (n < 60 && lat < 0) begin
            @(negedge clk);
            n++;
            if (ack[c]) lat = n;
        end
        if (lat < 0) begin
            tests++; fails++;
            $display("FAIL ack_timeout: got no ack on core %0d addr %h expected ack", c, a);
        end
        @(posedge clk); #1;
        if (c == 0) begin rd0 = 1'b0; wr0 = 1'b0; end
        else        begin rd1 = 1'b0; wr1 = 1'b0; end
    endtask

    task automatic rand_agent(input int c, input int n);
        int          op, gap, lat;
        logic [11:0] a;
        for (int k = 0; k < n; k++) begin
            op  = int'($urandom_range(0, 3));
            gap = int'($urandom_range(0, 3));
            a   = ((c == 0) ? 12'h200 : 12'h300) + 12'($urandom_range(0, 15));
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            txn(c, op != 1, op == 1 || op == 2, a, $urandom, lat);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"},   32'(ack), 32'd0);
        chk({tag, "_inv"},   32'(inv_valid), 32'd0);
        chk({tag, "_rden"},  32'(mem_rden), 32'd0);
        chk({tag, "_wren"},  32'(mem_wren), 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_iaddr"}, 32'(inv_addr), 32'd0);
        chk({tag, "_maddr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mdata"}, mem_data, 32'd0);
    endtask

    initial begin
        int lat, snap_r, snap_w, snap_a, n;
        for (int i = 0; i < 4096; i++) ref_mem[i] = pat(i);
        rst = 1'b0;
        rd0 = 1'b1; wr0 = 1'b0; a0 = 12'h001; d0 = '0;
        rd1 = 1'b1; wr1 = 1'b0; a1 = 12'h002; d1 = '0;
        #2 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk_reset_outputs("reset");
        end

        // Contention straight out of reset: core 0 first, then strict alternation.
        ordq = {0, 1, 0, 1, 0, 1, 0, 1};
        @(posedge clk); #1 rst = 1'b1;
        fork
            for (int k = 0; k < 4; k++) begin int l; txn(0, 1'b1, 1'b0, 12'h001, '0, l); end
            for (int k = 0; k < 4; k++) begin int l; txn(1, 1'b1, 1'b0, 12'h002, '0, l); end
        join
        chk("order_drained", 32'(ordq.size()), 32'd0);
        ordq.delete();

        repeat (2) @(posedge clk); #1;
        snap_r = rden_cnt;
        txn(0, 1'b1, 1'b0, 12'h010, '0, lat);
        chk("rd_latency", 32'(lat), 32'd4);
        chk("rd_pulses", 32'(rden_cnt - snap_r), 32'd1);

        repeat (2) @(posedge clk); #1;
        snap_w = wren_cnt;
        txn(1, 1'b0, 1'b1, 12'h0A5, 32'h12345678, lat);
        chk("wr_latency", 32'(lat), 32'd3);
        chk("wr_pulses", 32'(wren_cnt - snap_w), 32'd1);
        chk("wr_addr", 32'(wr_addr_seen), 32'h0A5);
        chk("wr_data", wr_data_seen, 32'h12345678);
        txn(0, 1'b1, 1'b0, 12'h0A5, '0, lat);

        snap_r = rden_cnt;
        txn(0, 1'b1, 1'b1, 12'h100, 32'h55, lat);
        @(negedge clk);
        chk("rdwr_ram", ram[12'h100], 32'h55);
        chk("rdwr_no_rden", 32'(rden_cnt - snap_r), 32'd0);

        fork
            rand_agent(0, 30);
            rand_agent(1, 30);
        join
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            chk("ram_c0", ram[12'h200 + 12'(i)], ref_mem[12'h200 + 12'(i)]);
            chk("ram_c1", ram[12'h300 + 12'(i)], ref_mem[12'h300 + 12'(i)]);
        end

        // Abort a read while it waits on RAM data.
        repeat (2) @(posedge clk); #1;
        snap_a = ack_cnt;
        snap_r = rden_cnt;
        rd0 = 1'b1; a0 = 12'h020;
        n = 0;
        while (n < 20 && !mem_rden) begin @(negedge clk); n++; end
        if (!mem_rden) begin
            tests++; fails++;
            $display("FAIL abort_issue: got no mem_rden expected a pulse");
        end
        @(posedge clk); #2;
        rst = 1'b0;
        rd0 = 1'b0;
        #1 chk_reset_outputs("abort");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_no_ack", 32'(ack_cnt - snap_a), 32'd0);
        chk("abort_no_reissue", 32'(rden_cnt - snap_r), 32'd1);
        chk("abort_idle_rden", 32'(mem_rden), 32'd0);

        chk("q0_empty", 32'(q0.size()), 32'd0);
        chk("q1_empty", 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end
endmodule
